// File: rtl/ram_bist_pkg.sv
// March C- BIST shared types: element tables and FSM state encoding.
// Optional build macro: RAM_BIST_STOP_ON_FAIL_EN (used by ram_bist).
package ram_bist_pkg;

  typedef logic [2:0] elem_t;
  typedef logic [2:0] state_t;

  localparam int N_ELEM = 6;

  // Bit i of each table describes March element Mi.
  localparam logic [N_ELEM-1:0] EL_DOWN   = 6'b111000;
  localparam logic [N_ELEM-1:0] EL_HAS_RD = 6'b111110;
  localparam logic [N_ELEM-1:0] EL_HAS_WR = 6'b011111;
  localparam logic [N_ELEM-1:0] EL_RD_INV = 6'b010100;
  localparam logic [N_ELEM-1:0] EL_WR_INV = 6'b001010;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WR_ONLY = 3'd1;
  localparam state_t S_RD      = 3'd2;
  localparam state_t S_CMP_WR  = 3'd3;
  localparam state_t S_CMP     = 3'd4;
  localparam state_t S_FIN     = 3'd5;

  function automatic logic el_bit(
    input logic [N_ELEM-1:0] tbl,
    input elem_t             e
  );
    return tbl[e];
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter for the March sequencer.
// Flags the final address of the current sweep direction.
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic              ld_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      down <= 1'b0;
    end else if (ld) begin
      addr <= ld_down ? '1 : '0;
      down <= ld_down;
    end else if (step) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_bist.sv
// March C- memory BIST master for a single-port synchronous RAM.
// Define RAM_BIST_STOP_ON_FAIL_EN to abort the run at the first mismatch.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                 ADDR_W     = 4,
  parameter int                 DATA_W     = 4,
  parameter logic [DATA_W-1:0]  BG_PATTERN = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [DATA_W-1:0] mem_ip,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_op
);

  state_t state, state_nx;
  elem_t  elem, elem_nx, elem_inc;

  logic              ld, ld_down, step, last;
  logic              accept, cmp, err, kill, wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_exp, wr_dat;

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (ld),
    .ld_down (ld_down),
    .step    (step),
    .addr    (addr),
    .last    (last)
  );

  assign elem_inc = elem + elem_t'(1);
  assign accept   = (state == S_IDLE) && start;

  assign rd_exp = el_bit(EL_RD_INV, elem) ? ~BG_PATTERN : BG_PATTERN;
  assign wr_dat = el_bit(EL_WR_INV, elem) ? ~BG_PATTERN : BG_PATTERN;

  assign cmp = (state == S_CMP_WR) || (state == S_CMP);
  assign err = cmp && (mem_op != rd_exp);

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  // The failing cell is left untouched so it can be inspected afterwards.
  assign kill = err;
`else
  assign kill = 1'b0;
`endif

  assign wr_en = (state == S_WR_ONLY) ||
                 ((state == S_CMP_WR) && !kill);

  assign mem_rd_wr   = ~wr_en;
  assign mem_ip      = wr_en ? wr_dat : '0;
  assign mem_address = addr;

  assign busy = (state == S_WR_ONLY) || (state == S_RD) ||
                (state == S_CMP_WR)  || (state == S_CMP);

  always_comb begin
    state_nx = state;
    elem_nx  = elem;
    ld       = 1'b0;
    ld_down  = 1'b0;
    step     = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (start) begin
          state_nx = S_WR_ONLY;
          elem_nx  = '0;
          ld       = 1'b1;
        end
      end
      (state == S_WR_ONLY),
      (state == S_CMP_WR): begin
        if (last) begin
          elem_nx  = elem_inc;
          ld       = 1'b1;
          ld_down  = el_bit(EL_DOWN, elem_inc);
          state_nx = el_bit(EL_HAS_RD, elem_inc) ?
                     S_RD : S_WR_ONLY;
        end else begin
          step     = 1'b1;
          state_nx = (state == S_WR_ONLY) ? S_WR_ONLY : S_RD;
        end
      end
      (state == S_RD): begin
        state_nx = el_bit(EL_HAS_WR, elem) ? S_CMP_WR : S_CMP;
      end
      (state == S_CMP): begin
        if (last) begin
          state_nx = S_FIN;
        end else begin
          step     = 1'b1;
          state_nx = S_RD;
        end
      end
      (state == S_FIN): begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (kill) begin
      state_nx = S_FIN;
    end
    // Park the address at 0 so idle outputs match reset values.
    if (state_nx == S_FIN) begin
      ld      = 1'b1;
      ld_down = 1'b0;
      step    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      elem      <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else begin
      state <= state_nx;
      elem  <= elem_nx;
      if (accept) begin
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else begin
        if (state_nx == S_FIN) begin
          done <= 1'b1;
        end
        if (err) begin
          fail <= 1'b1;
          if (!fail) begin
            fail_addr <= addr;
            fail_exp  <= rd_exp;
            fail_got  <= mem_op;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed scoreboard bench for ram_bist with behavioural RAMs.
// Instance 0 uses default background (fault injectable), instance 1 uses 1010.
module tb_ram_bist;

  logic clk, rst_n;
  logic start0, start1;

  logic       busy0, done0, fail0, rw0;
  logic [3:0] fa0, fe0, fg0, ip0, a0, op0;
  logic       busy1, done1, fail1, rw1;
  logic [3:0] fa1, fe1, fg1, ip1, a1, op1;

  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];
  logic [3:0] flt_addr, flt_mask;

  ram_bist u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .busy        (busy0),
    .done        (done0),
    .fail        (fail0),
    .fail_addr   (fa0),
    .fail_exp    (fe0),
    .fail_got    (fg0),
    .mem_ip      (ip0),
    .mem_rd_wr   (rw0),
    .mem_address (a0),
    .mem_op      (op0)
  );

  ram_bist #(.BG_PATTERN(4'b1010)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .busy        (busy1),
    .done        (done1),
    .fail        (fail1),
    .fail_addr   (fa1),
    .fail_exp    (fe1),
    .fail_got    (fg1),
    .mem_ip      (ip1),
    .mem_rd_wr   (rw1),
    .mem_address (a1),
    .mem_op      (op1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read latency 1; the stuck-at mask models a faulty cell on instance 0.
  always @(posedge clk) begin
    if (!rw0) mem0[a0] <= ip0;
    op0 <= mem0[a0] | ((a0 == flt_addr) ? flt_mask : 4'b0000);
  end

  always @(posedge clk) begin
    if (!rw1) mem1[a1] <= ip1;
    op1 <= mem1[a1];
  end

  logic       sel;
  logic       c_busy, c_done, c_fail, c_rw;
  logic [3:0] c_fa, c_fe, c_fg, c_ip, c_a;

  assign c_busy = sel ? busy1 : busy0;
  assign c_done = sel ? done1 : done0;
  assign c_fail = sel ? fail1 : fail0;
  assign c_rw   = sel ? rw1   : rw0;
  assign c_fa   = sel ? fa1   : fa0;
  assign c_fe   = sel ? fe1   : fe0;
  assign c_fg   = sel ? fg1   : fg0;
  assign c_ip   = sel ? ip1   : ip0;
  assign c_a    = sel ? a1    : a0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] wlog [$];
  int         vectors;
  int         miscompares;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty got=%0h", got);
    end else begin
      e = sb.pop_front();
      assert (got === e.val) else begin
        miscompares++;
        $error("FAIL %s got=%0h exp=%0h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    push(t, exp);
    pop_chk(got);
  endtask

  task automatic drive_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic check_idle_vals(input string t);
    chk({t, "_busy"}, 32'(c_busy), 32'd0);
    chk({t, "_done"}, 32'(c_done), 32'd0);
    chk({t, "_fail"}, 32'(c_fail), 32'd0);
    chk({t, "_faddr"}, 32'(c_fa), 32'd0);
    chk({t, "_fexp"}, 32'(c_fe), 32'd0);
    chk({t, "_fgot"}, 32'(c_fg), 32'd0);
    chk({t, "_rdwr"}, 32'(c_rw), 32'd1);
    chk({t, "_addr"}, 32'(c_a), 32'd0);
    chk({t, "_ip"}, 32'(c_ip), 32'd0);
  endtask

  // Pulse start, then count busy cycles and log writes until done.
  task automatic run(input int repulse_at, input int abort_at,
                     output int cyc, output logic to);
    cyc = 0;
    to  = 1'b1;
    wlog.delete();
    @(negedge clk);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    for (int k = 0; k < 2000; k++) begin
      if (c_busy) begin
        cyc++;
        if (!c_rw) wlog.push_back({c_a, c_ip});
      end
      if (abort_at > 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        to = 1'b0;
        return;
      end
      if (repulse_at > 0 && c_busy && cyc == repulse_at)
        drive_start(1'b1);
      if (c_done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      drive_start(1'b0);
    end
  endtask

  int   cyc;
  logic to;
  int   exp_cyc;
  int   exp_nwr;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start0      = 1'b0;
    start1      = 1'b0;
    sel         = 1'b0;
    flt_addr    = 4'd0;
    flt_mask    = 4'd0;

    repeat (3) @(negedge clk);
    check_idle_vals("rst0");
    sel = 1'b1;
    check_idle_vals("rst1");
    sel = 1'b0;
    rst_n = 1'b1;

    // Fault-free default run.
    run(0, 0, cyc, to);
    chk("t1_timeout", 32'(to), 32'd0);
    chk("t1_cycles", 32'(cyc), 32'd176);
    chk("t1_done", 32'(c_done), 32'd1);
    chk("t1_busy", 32'(c_busy), 32'd0);
    chk("t1_fail", 32'(c_fail), 32'd0);
    chk("t1_nwr", 32'(wlog.size()), 32'd80);
    for (int i = 0; i < 16; i++) push("t1_m0_wr", {24'd0, 4'(i), 4'h0});
    for (int i = 0; i < 16; i++) pop_chk(32'(wlog[i]));

    // Bit 2 of address 5 stuck at 1.
    flt_addr = 4'd5;
    flt_mask = 4'b0100;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    exp_cyc = 28;
    exp_nwr = 21;
`else
    exp_cyc = 176;
    exp_nwr = 80;
`endif
    run(0, 0, cyc, to);
    chk("t2_timeout", 32'(to), 32'd0);
    chk("t2_cycles", 32'(cyc), 32'(exp_cyc));
    chk("t2_nwr", 32'(wlog.size()), 32'(exp_nwr));
    chk("t2_done", 32'(c_done), 32'd1);
    chk("t2_fail", 32'(c_fail), 32'd1);
    chk("t2_faddr", 32'(c_fa), 32'd5);
    chk("t2_fexp", 32'(c_fe), 32'h0);
    chk("t2_fgot", 32'(c_fg), 32'h4);

    // Start re-pulsed mid-test is ignored.
    flt_mask = 4'b0000;
    run(40, 0, cyc, to);
    chk("t3_timeout", 32'(to), 32'd0);
    chk("t3_cycles", 32'(cyc), 32'd176);
    chk("t3_fail", 32'(c_fail), 32'd0);
    chk("t3_faddr", 32'(c_fa), 32'd0);
    chk("t3_nwr", 32'(wlog.size()), 32'd80);
    @(negedge clk);
    chk("t3_idle_busy", 32'(c_busy), 32'd0);
    chk("t3_idle_done", 32'(c_done), 32'd1);

    // Reset mid-test, then a clean rerun.
    run(0, 50, cyc, to);
    chk("t4_abort_at", 32'(cyc), 32'd50);
    check_idle_vals("t4_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, cyc, to);
    chk("t4_timeout", 32'(to), 32'd0);
    chk("t4_cycles", 32'(cyc), 32'd176);
    chk("t4_done", 32'(c_done), 32'd1);
    chk("t4_fail", 32'(c_fail), 32'd0);

    // Background pattern 1010.
    sel = 1'b1;
    run(0, 0, cyc, to);
    chk("t5_timeout", 32'(to), 32'd0);
    chk("t5_cycles", 32'(cyc), 32'd176);
    chk("t5_done", 32'(c_done), 32'd1);
    chk("t5_fail", 32'(c_fail), 32'd0);
    chk("t5_nwr", 32'(wlog.size()), 32'd80);
    for (int i = 0; i < 16; i++) push("t5_m0_wr", {24'd0, 4'(i), 4'hA});
    for (int i = 0; i < 16; i++) push("t5_m1_wr", {24'd0, 4'(i), 4'h5});
    for (int i = 0; i < 32; i++) pop_chk(32'(wlog[i]));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
